uart_rx: RTL
============

// Module: uart_rx
// PURPOSE
//  - 8N1 UART receiver: deserialises the host serial line into bytes for the command state machine.
//  - Drives that block's received/rx_byte inputs: one byte per single-cycle received pulse.
//  - Sits between the FTDI RX pin and the command decoder.
//  - Reports framing errors separately so the decoder never sees a corrupt byte.
// PARAMETERS
//  CLKS_PER_BIT   104   clk cycles per bit period (12 MHz / 115200 baud); legal range >= 8
//  SYNC_STAGES    2     depth of the rx input synchroniser; legal range >= 2
// PORTS
//  clk          in   1  system clock; the only clock
//  rst          in   1  reset, synchronous, active-high
//  rx           in   1  asynchronous serial line, idles high
//  received     out  1  one-cycle pulse: rx_byte holds a new valid byte
//  rx_byte      out  8  last good byte, LSB received first
//  frame_error  out  1  one-cycle pulse: stop bit sampled low
//  busy         out  1  high from start-bit detect until return to IDLE
// BEHAVIOUR
//  - Reset: all outputs 0; synchroniser flops = 1 (line idle); FSM = IDLE; counters = 0.
//  - rx passes through SYNC_STAGES flops. rxs is the synchronised line, the only copy the FSM reads.
//  - Bit counter cnt is $clog2(CLKS_PER_BIT) bits wide. Bit index idx is 3 bits.
//  - IDLE: when rxs==0, go to START with cnt=0 and busy=1.
//  - START: count to CLKS_PER_BIT/2-1 (integer divide), then sample rxs.
//    - rxs==1: glitch. Go to IDLE with no output pulse.
//    - rxs==0: go to DATA with cnt=0 and idx=0.
//  - DATA: count to CLKS_PER_BIT-1, then shift rxs into the MSB of the shift register.
//    - idx 7 -> 0 wraps to STOP. Otherwise idx++.
//  - STOP: count to CLKS_PER_BIT-1, then sample rxs.
//    - rxs==1: copy shift reg to rx_byte and pulse received for exactly 1 cycle. Go to IDLE.
//    - rxs==0: pulse frame_error for 1 cycle; rx_byte is unchanged. Go to WAIT_IDLE.
//  - WAIT_IDLE (break or line stuck low): stay until rxs==1, then go to IDLE.
//  - Latency: received asserts on the cycle after the mid-stop-bit sample.
//    - From the start-bit falling edge at the pin: SYNC_STAGES + ~9.5*CLKS_PER_BIT cycles.
//  - received and frame_error are never high together.
//  - Neither output is high for two consecutive cycles.
//  - rx_byte is stable between received pulses. The consumer may read it any time after the pulse.
//  - Back-to-back frames: IDLE is re-entered mid-stop-bit. A start edge arriving half a bit later must be caught.
//  - busy is 0 in IDLE and 1 in every other state, including WAIT_IDLE.
//  - rst mid-frame: abort on the next edge. No pulse is emitted. The partial byte is discarded.
//  - rx_byte returns to 0 on reset.
//  - No flow control and no FIFO: a byte is overwritten by the next one if unconsumed.
// STRUCTURE
//  - Shared include uart_defs.vh holds:
//    - state encodings: IDLE=0, START=1, DATA=2, STOP=3, WAIT_IDLE=4
//    - default CLKS_PER_BIT (104), so the matching transmitter uses the same value.
//  - One sub-module, sync_ff(WIDTH=1, STAGES, RESET_VAL=1). It is reused for other async pins.
//  - Everything else is a single always block plus a registered output stage.
// TESTING
//  - Run the bench at CLKS_PER_BIT=16 for speed; one case also runs at 104.
//  1. Send 0x55, then 0xA3 (8N1, exact baud).
//     -> received pulses twice, 1 cycle each; rx_byte = 0x55, then 0xA3; frame_error never high.
//  2. Low glitch of CLKS_PER_BIT/4 cycles on an idle line
//     -> no received or frame_error pulse; busy returns to 0 before CLKS_PER_BIT cycles.
//  3. Frame 0x3C with the stop bit held low for 3 bit times, then high, then a good 0x81
//     -> one frame_error pulse; rx_byte stays at its old value; then received with 0x81.
//  4. Five frames 0x00, 0xFF, 0x01, 0x80, 0x7E back-to-back, stop bit exactly 1 bit long,
//     baud skewed +-2% -> five received pulses with matching bytes.
//  5. rst asserted for 1 cycle during data bit 4 of 0xC6, then a clean 0x12
//     -> no pulse for 0xC6; outputs = 0 after reset; received with rx_byte = 0x12.
//  6. Latency check at CLKS_PER_BIT=104: measure from the start edge to received
//     -> 2 + 104/2 + 9*104 cycles (+-1).

Source files
------------

// File: rtl/uart_rx_pkg.sv
// uart_rx shared definitions.
// FSM state encoding and default bit period, shared with the transmitter.
package uart_rx_pkg;

  localparam int DEF_CLKS_PER_BIT = 104;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_IDLE = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sync_ff.sv
// sync_ff: multi-flop synchroniser for asynchronous input pins.
// Flops reset to RESET_VAL so an idle-high line looks idle after reset.
module sync_ff #(
  parameter int                WIDTH     = 1,
  parameter int                STAGES    = 2,
  parameter logic [WIDTH-1:0]  RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [STAGES-1:0][WIDTH-1:0] r_pipe;

  // shift the pin through STAGES flops
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pipe <= {STAGES{RESET_VAL}};
    end else begin
      r_pipe <= {r_pipe[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_pipe[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with framing-error reporting.
// Samples mid-bit off a synchronised copy of the line.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       received,
  output logic [7:0] rx_byte,
  output logic       frame_error,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  logic          w_rxs;
  rx_state_e     r_state;
  rx_state_e     w_state;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt;
  logic [2:0]    r_idx;
  logic [2:0]    w_idx;
  logic [7:0]    r_shift;
  logic [7:0]    w_shift;
  logic          w_rcv;
  logic          w_ferr;
  logic          r_received;
  logic          r_frame_error;
  logic [7:0]    r_rx_byte;

  sync_ff #(
    .WIDTH     (1),
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (rx),
    .o_q (w_rxs)
  );

  // next-state, counters and shift register
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_idx   = r_idx;
    w_shift = r_shift;
    w_rcv   = 1'b0;
    w_ferr  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!w_rxs) begin
          w_state = S_START;
          w_cnt   = '0;
        end
      end
      S_START: begin
        if (r_cnt == HALF_LAST) begin
          w_cnt = '0;
          if (w_rxs) begin
            w_state = S_IDLE;
          end else begin
            w_state = S_DATA;
            w_idx   = 3'd0;
          end
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (r_cnt == BIT_LAST) begin
          w_cnt   = '0;
          w_shift = {w_rxs, r_shift[7:1]};
          w_idx   = r_idx + 3'd1;
          if (r_idx == 3'd7) begin
            w_state = S_STOP;
          end
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (r_cnt == BIT_LAST) begin
          w_cnt = '0;
          if (w_rxs) begin
            w_rcv   = 1'b1;
            w_state = S_IDLE;
          end else begin
            w_ferr  = 1'b1;
            w_state = S_WAIT_IDLE;
          end
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      S_WAIT_IDLE: begin
        if (w_rxs) begin
          w_state = S_IDLE;
        end
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  // FSM state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= 3'd0;
      r_shift <= 8'd0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_idx   <= w_idx;
      r_shift <= w_shift;
    end
  end

  // registered outputs; byte only updates on a good frame
  always_ff @(posedge clk) begin
    if (rst) begin
      r_received    <= 1'b0;
      r_frame_error <= 1'b0;
      r_rx_byte     <= 8'd0;
    end else begin
      r_received    <= w_rcv;
      r_frame_error <= w_ferr;
      if (w_rcv) begin
        r_rx_byte <= r_shift;
      end
    end
  end

  assign received    = r_received;
  assign frame_error = r_frame_error;
  assign rx_byte     = r_rx_byte;
  assign busy        = (r_state != S_IDLE);

endmodule
